// File: rtl/user_stream_loopback_hub_if.sv
// Register bus, stream and interrupt signals of user_stream_loopback_hub.
// The slave modport is the hub's view; the master modport is the bridge/host side.
interface user_stream_loopback_hub_if #(
    parameter int NUM_STR = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 20
);
    logic [31:0]             i_user_data;
    logic [ADDR_W-1:0]       i_user_addr;
    logic                    i_user_wr_req;
    logic                    i_user_rd_req;
    logic [31:0]             o_user_data;
    logic                    o_user_rd_ack;
    logic [NUM_STR-1:0]        i_pcie_str_data_valid;
    logic [NUM_STR*DATA_W-1:0] i_pcie_str_data;
    logic [NUM_STR-1:0]        o_pcie_str_ack;
    logic [NUM_STR-1:0]        o_pcie_str_data_valid;
    logic [NUM_STR*DATA_W-1:0] o_pcie_str_data;
    logic [NUM_STR-1:0]        i_pcie_str_ack;
    logic                    o_intr_req;
    logic                    i_intr_ack;

    modport slave (
        input  i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
        output o_user_data, o_user_rd_ack,
        input  i_pcie_str_data_valid, i_pcie_str_data,
        output o_pcie_str_ack,
        output o_pcie_str_data_valid, o_pcie_str_data,
        input  i_pcie_str_ack,
        output o_intr_req,
        input  i_intr_ack
    );

    modport master (
        output i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
        input  o_user_data, o_user_rd_ack,
        output i_pcie_str_data_valid, i_pcie_str_data,
        input  o_pcie_str_ack,
        input  o_pcie_str_data_valid, o_pcie_str_data,
        output i_pcie_str_ack,
        input  o_intr_req,
        output i_intr_ack
    );
endinterface

// File: rtl/user_stream_loopback_hub.sv
// N-channel stream loopback endpoint: per-channel FIFOs, register file, word counters.
// Define USER_STR_INTR_EN to build the THRESH register and the req/ack interrupt FSM.
module user_stream_loopback_hub #(
    parameter int NUM_STR    = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = 20
) (
    input  logic i_user_clk,
    input  logic i_rst,
    user_stream_loopback_hub_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h04);

    logic [NUM_STR-1:0] en_q, en_d;
    logic [PTR_W-1:0]   wr_ptr_q [NUM_STR];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_STR];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_STR];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_STR];
    logic [OCC_W-1:0]   occ_q    [NUM_STR];
    logic [OCC_W-1:0]   occ_d    [NUM_STR];
    logic [31:0]        cnt_q    [NUM_STR];
    logic [31:0]        cnt_d    [NUM_STR];
    logic [DATA_W-1:0]  mem_q    [NUM_STR][FIFO_DEPTH];
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_ack_q, rd_ack_d;

    logic [NUM_STR-1:0]        full, empty, in_ack, out_vld, push, pop;
    logic [NUM_STR*DATA_W-1:0] out_data;
    logic [31:0]               status;
    logic                      wr_ctrl, soft_clr;

    always_comb begin
        full     = '0;
        empty    = '0;
        in_ack   = '0;
        out_vld  = '0;
        push     = '0;
        pop      = '0;
        out_data = '0;
        for (int n = 0; n < NUM_STR; n++) begin
            full[n]    = (occ_q[n] == OCC_W'(FIFO_DEPTH));
            empty[n]   = (occ_q[n] == '0);
            in_ack[n]  = en_q[n] & ~full[n];
            out_vld[n] = en_q[n] & ~empty[n];
            push[n]    = in_ack[n] & bus.i_pcie_str_data_valid[n];
            pop[n]     = out_vld[n] & bus.i_pcie_str_ack[n];
            out_data[n*DATA_W +: DATA_W] = mem_q[n][rd_ptr_q[n]];
        end
    end

    // Soft clear takes effect on the same edge as the CTRL write, so the flushed
    // state is visible from the following cycle.
    always_comb begin
        wr_ctrl  = bus.i_user_wr_req && (bus.i_user_addr == ADDR_CTRL);
        soft_clr = wr_ctrl && bus.i_user_data[31];
        en_d     = en_q;
        if (wr_ctrl) begin
            en_d = bus.i_user_data[NUM_STR-1:0];
        end
        for (int n = 0; n < NUM_STR; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(push[n]);
            rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(pop[n]);
            occ_d[n]    = occ_q[n] + OCC_W'(push[n]) - OCC_W'(pop[n]);
            cnt_d[n]    = cnt_q[n] + 32'(pop[n]);
            if (soft_clr) begin
                wr_ptr_d[n] = '0;
                rd_ptr_d[n] = '0;
                occ_d[n]    = '0;
                cnt_d[n]    = '0;
            end
        end
    end

    always_comb begin
        status = '0;
        status[NUM_STR-1:0]  = empty;
        status[8 +: NUM_STR] = full;
    end

`ifdef USER_STR_INTR_EN
    localparam logic [ADDR_W-1:0] ADDR_THRESH = ADDR_W'(32'h08);

    typedef enum logic {INTR_IDLE, INTR_REQ} intr_state_t;

    intr_state_t state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] thresh_q, thresh_d;
    logic        intr_event;

    // An event seen while idle raises the request directly; events while a
    // request is outstanding are remembered in pend for the next round.
    always_comb begin
        thresh_d = thresh_q;
        if (bus.i_user_wr_req && (bus.i_user_addr == ADDR_THRESH)) begin
            thresh_d = bus.i_user_data;
        end
        intr_event = 1'b0;
        for (int n = 0; n < NUM_STR; n++) begin
            if (pop[n] && (cnt_q[n] + 32'd1 == thresh_q) && (thresh_q != '0)) begin
                intr_event = 1'b1;
            end
        end
        state_d = state_q;
        pend_d  = pend_q | intr_event;
        case (state_q)
            INTR_IDLE: begin
                if (pend_q || intr_event) begin
                    state_d = INTR_REQ;
                    pend_d  = 1'b0;
                end
            end
            INTR_REQ: begin
                if (bus.i_intr_ack) begin
                    state_d = INTR_IDLE;
                end
            end
            default: state_d = INTR_IDLE;
        endcase
        if (soft_clr) begin
            state_d = INTR_IDLE;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            state_q  <= INTR_IDLE;
            pend_q   <= 1'b0;
            thresh_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            thresh_q <= thresh_d;
        end
    end

    assign bus.o_intr_req = (state_q == INTR_REQ);
`else
    logic unused_intr;
    assign unused_intr    = ^{bus.i_intr_ack, bus.i_user_data};
    assign bus.o_intr_req = 1'b0;
`endif

    // Read data is muxed from registered state, so a same-cycle write is not visible.
    always_comb begin
        rd_ack_d  = bus.i_user_rd_req;
        rd_data_d = '0;
        if (bus.i_user_rd_req) begin
            if (bus.i_user_addr == ADDR_CTRL) begin
                rd_data_d = 32'(en_q);
            end
            if (bus.i_user_addr == ADDR_STATUS) begin
                rd_data_d = status;
            end
`ifdef USER_STR_INTR_EN
            if (bus.i_user_addr == ADDR_THRESH) begin
                rd_data_d = thresh_q;
            end
`endif
            for (int n = 0; n < NUM_STR; n++) begin
                if (bus.i_user_addr == ADDR_W'(32'h10 + 4 * n)) begin
                    rd_data_d = cnt_q[n];
                end
            end
        end
    end

    always_ff @(posedge i_user_clk) begin
        if (i_rst) begin
            en_q      <= '0;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            for (int n = 0; n < NUM_STR; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                occ_q[n]    <= '0;
                cnt_q[n]    <= '0;
            end
        end else begin
            en_q      <= en_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            for (int n = 0; n < NUM_STR; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                occ_q[n]    <= occ_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
        end
    end

    // Storage has no reset; occupancy alone defines which entries are live.
    always_ff @(posedge i_user_clk) begin
        for (int n = 0; n < NUM_STR; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= bus.i_pcie_str_data[n*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.o_pcie_str_ack        = in_ack;
    assign bus.o_pcie_str_data_valid = out_vld;
    assign bus.o_pcie_str_data       = out_data;
    assign bus.o_user_data           = rd_data_q;
    assign bus.o_user_rd_ack         = rd_ack_q;
endmodule

// File: tb/tb_user_stream_loopback_hub.sv
// Scoreboard bench for user_stream_loopback_hub; interrupt checks follow USER_STR_INTR_EN.
module tb_user_stream_loopback_hub;
    localparam int NUM_STR    = 4;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 512;
    localparam int ADDR_W     = 20;
`ifdef USER_STR_INTR_EN
    localparam bit INTR_BUILD = 1'b1;
`else
    localparam bit INTR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0] val;
        int          due;
        logic [31:0] addr;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [DATA_W-1:0]  exp_q [NUM_STR][$];
    int unsigned        exp_cnt [NUM_STR];
    logic [NUM_STR-1:0] last_acc = '0;
    rd_exp_t            rd_q [$];
    rd_exp_t            mon_e;

    user_stream_loopback_hub_if #(.NUM_STR(NUM_STR), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    user_stream_loopback_hub #(
        .NUM_STR(NUM_STR), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .i_user_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Records every accepted host->card word as the expected card->host word.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < NUM_STR; n++) begin
                last_acc[n] = bus.i_pcie_str_data_valid[n] & bus.o_pcie_str_ack[n];
                if (last_acc[n]) begin
                    exp_q[n].push_back(bus.i_pcie_str_data[n*DATA_W +: DATA_W]);
                    exp_cnt[n]++;
                end
            end
        end
    end

    // Compares every returned word and every read response against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < NUM_STR; n++) begin
                if (bus.o_pcie_str_data_valid[n] && bus.i_pcie_str_ack[n]) begin
                    if (exp_q[n].size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL ch%0d_unexpected_word: got 0x%0h expected none",
                                 n, bus.o_pcie_str_data[n*DATA_W +: DATA_W]);
                    end else begin
                        check_output($sformatf("ch%0d_data", n),
                                     bus.o_pcie_str_data[n*DATA_W +: DATA_W], exp_q[n].pop_front());
                    end
                end
            end
            if (bus.o_user_rd_ack) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rd_unexpected_ack: got data 0x%0h expected no ack", bus.o_user_data);
                end else begin
                    mon_e = rd_q.pop_front();
                    check_output($sformatf("rd_ack_cycle_0x%0h", mon_e.addr), 64'(cyc), 64'(mon_e.due));
                    check_output($sformatf("rd_data_0x%0h", mon_e.addr), 64'(bus.o_user_data), 64'(mon_e.val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.i_user_addr   = a;
        bus.i_user_data   = d;
        bus.i_user_wr_req = 1'b1;
        tick();
        bus.i_user_wr_req = 1'b0;
    endtask

    task automatic reg_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        rd_q.push_back('{val: exp, due: cyc + 1, addr: 32'(a)});
        bus.i_user_addr   = a;
        bus.i_user_rd_req = 1'b1;
        tick();
        bus.i_user_rd_req = 1'b0;
        tick();
    endtask

    task automatic drain(input logic [NUM_STR-1:0] mask);
        int budget = 4 * FIFO_DEPTH + 100;
        bit done;
        bus.i_pcie_str_ack = mask;
        do begin
            tick();
            done = 1'b1;
            for (int n = 0; n < NUM_STR; n++) begin
                if (mask[n] && exp_q[n].size() != 0) done = 1'b0;
            end
            budget--;
        end while (!done && budget > 0);
        bus.i_pcie_str_ack = '0;
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL drain_timeout: got words still outstanding expected all returned");
        end
    endtask

    // Streams on every channel with random back-pressure until all words are returned.
    task automatic apply_stimulus(input int words, input int bp_pct);
        int sent [NUM_STR];
        int budget = 40000;
        bit done;
        for (int n = 0; n < NUM_STR; n++) sent[n] = 0;
        bus.i_pcie_str_data_valid = '0;
        do begin
            tick();
            done = 1'b1;
            for (int n = 0; n < NUM_STR; n++) begin
                if (bus.i_pcie_str_data_valid[n] && last_acc[n]) begin
                    sent[n]++;
                    bus.i_pcie_str_data_valid[n] = 1'b0;
                end
                if (!bus.i_pcie_str_data_valid[n] && sent[n] < words) begin
                    bus.i_pcie_str_data_valid[n] = 1'b1;
                    bus.i_pcie_str_data[n*DATA_W +: DATA_W] = {8'(n), 24'h5A5A5A, 32'(sent[n])};
                end
                bus.i_pcie_str_ack[n] = ($urandom_range(0, 99) >= bp_pct);
                if (sent[n] < words || exp_q[n].size() != 0) done = 1'b0;
            end
            budget--;
        end while (!done && budget > 0);
        bus.i_pcie_str_data_valid = '0;
        bus.i_pcie_str_ack        = '0;
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL stream_timeout: got incomplete transfer expected %0d words per channel", words);
        end
    endtask

    initial begin
        bus.i_user_data           = '0;
        bus.i_user_addr           = '0;
        bus.i_user_wr_req         = 1'b0;
        bus.i_user_rd_req         = 1'b0;
        bus.i_pcie_str_data_valid = '0;
        bus.i_pcie_str_data       = '0;
        bus.i_pcie_str_ack        = '0;
        bus.i_intr_ack            = 1'b0;
        for (int n = 0; n < NUM_STR; n++) exp_cnt[n] = 0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_output("rst_in_ack",  64'(bus.o_pcie_str_ack), 64'h0);
        check_output("rst_out_vld", 64'(bus.o_pcie_str_data_valid), 64'h0);
        check_output("rst_rd_ack",  64'(bus.o_user_rd_ack), 64'h0);
        check_output("rst_rd_data", 64'(bus.o_user_data), 64'h0);
        check_output("rst_intr",    64'(bus.o_intr_req), 64'h0);
        rst = 1'b0;
        tick();
        reg_read(ADDR_W'(32'h00), 32'h0);
        reg_read(ADDR_W'(32'h04), 32'h0000_000F);
        reg_read(ADDR_W'(32'h08), 32'h0);

        // Single word on ch0 with latency 1
        reg_write(ADDR_W'(32'h00), 32'h1);
        bus.i_pcie_str_ack[0] = 1'b1;
        bus.i_pcie_str_data[0 +: DATA_W] = 64'h0123_4567_89AB_CDEF;
        bus.i_pcie_str_data_valid[0] = 1'b1;
        @(negedge clk);
        check_output("t1_vld_before_push", 64'(bus.o_pcie_str_data_valid[0]), 64'h0);
        check_output("t1_in_ack", 64'(bus.o_pcie_str_ack[0]), 64'h1);
        tick();
        bus.i_pcie_str_data_valid[0] = 1'b0;
        @(negedge clk);
        check_output("t1_vld_after_push", 64'(bus.o_pcie_str_data_valid[0]), 64'h1);
        tick();
        bus.i_pcie_str_ack[0] = 1'b0;
        @(negedge clk);
        check_output("t1_vld_after_pop", 64'(bus.o_pcie_str_data_valid[0]), 64'h0);
        tick();
        reg_read(ADDR_W'(32'h10), 32'd1);

        // Read and write in the same cycle; unmapped and read-only accesses
        rd_q.push_back('{val: 32'h1, due: cyc + 1, addr: 32'h0});
        bus.i_user_addr   = ADDR_W'(32'h00);
        bus.i_user_data   = 32'h3;
        bus.i_user_wr_req = 1'b1;
        bus.i_user_rd_req = 1'b1;
        tick();
        bus.i_user_wr_req = 1'b0;
        bus.i_user_rd_req = 1'b0;
        tick();
        reg_read(ADDR_W'(32'h00), 32'h3);
        reg_read(ADDR_W'(32'hFFC), 32'h0);
        reg_write(ADDR_W'(32'h0C), 32'hDEAD_BEEF);
        reg_read(ADDR_W'(32'h0C), 32'h0);
        reg_write(ADDR_W'(32'h04), 32'hFFFF_FFFF);
        reg_read(ADDR_W'(32'h04), 32'h0000_000F);

        // Fill ch1 to the brim, then free a single slot
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus.i_pcie_str_data[DATA_W +: DATA_W] = {32'hC1C1_0000, 32'(i)};
            bus.i_pcie_str_data_valid[1] = 1'b1;
            if (i == FIFO_DEPTH - 1) begin
                @(negedge clk);
                check_output("t2_ack_last_slot", 64'(bus.o_pcie_str_ack[1]), 64'h1);
            end
            tick();
        end
        bus.i_pcie_str_data[DATA_W +: DATA_W] = 64'h0000_0BAD_0000_0BAD;
        @(negedge clk);
        check_output("t2_ack_full", 64'(bus.o_pcie_str_ack[1]), 64'h0);
        tick();
        reg_read(ADDR_W'(32'h04), 32'h0000_020D);
        bus.i_pcie_str_ack[1] = 1'b1;
        @(negedge clk);
        check_output("t2_ack_full_while_pop", 64'(bus.o_pcie_str_ack[1]), 64'h0);
        tick();
        bus.i_pcie_str_ack[1] = 1'b0;
        @(negedge clk);
        check_output("t2_ack_after_pop", 64'(bus.o_pcie_str_ack[1]), 64'h1);
        tick();
        bus.i_pcie_str_data_valid[1] = 1'b0;
        drain(4'b0010);

        // All channels with random back-pressure
        reg_write(ADDR_W'(32'h00), 32'hF);
        apply_stimulus(2500, 30);
        @(negedge clk);
        check_output("t3_no_intr", 64'(bus.o_intr_req), 64'h0);
        tick();
        for (int n = 0; n < NUM_STR; n++) begin
            reg_read(ADDR_W'(32'h10 + 4 * n), 32'(exp_cnt[n]));
        end

        // Soft clear with words still buffered
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < NUM_STR; n++) begin
                bus.i_pcie_str_data[n*DATA_W +: DATA_W] = {8'(n), 24'hC1EA5E, 32'(i)};
            end
            bus.i_pcie_str_data_valid = '1;
            tick();
        end
        bus.i_pcie_str_data_valid = '0;
        reg_write(ADDR_W'(32'h00), 32'h8000_000F);
        for (int n = 0; n < NUM_STR; n++) begin
            exp_q[n].delete();
            exp_cnt[n] = 0;
        end
        @(negedge clk);
        check_output("t5_vld_flushed", 64'(bus.o_pcie_str_data_valid), 64'h0);
        check_output("t5_in_ack", 64'(bus.o_pcie_str_ack), 64'hF);
        tick();
        reg_read(ADDR_W'(32'h04), 32'h0000_000F);
        reg_read(ADDR_W'(32'h00), 32'h0000_000F);
        for (int n = 0; n < NUM_STR; n++) begin
            reg_read(ADDR_W'(32'h10 + 4 * n), 32'h0);
        end
        bus.i_pcie_str_data[0 +: DATA_W] = 64'hF00D_CAFE_0000_0001;
        bus.i_pcie_str_data_valid[0] = 1'b1;
        tick();
        bus.i_pcie_str_data_valid[0] = 1'b0;
        drain(4'b0001);

        // Threshold interrupt on ch2, second event from ch3 while requesting
        reg_write(ADDR_W'(32'h08), 32'd16);
        reg_read(ADDR_W'(32'h08), INTR_BUILD ? 32'd16 : 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.i_pcie_str_data[2*DATA_W +: DATA_W] = {32'hC2C2_0000, 32'(i)};
            bus.i_pcie_str_data[3*DATA_W +: DATA_W] = {32'hC3C3_0000, 32'(i)};
            bus.i_pcie_str_data_valid[3:2] = 2'b11;
            tick();
        end
        bus.i_pcie_str_data_valid = '0;
        bus.i_pcie_str_ack[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                @(negedge clk);
                check_output("t4_req_before_16th", 64'(bus.o_intr_req), 64'h0);
            end
            tick();
        end
        bus.i_pcie_str_ack[2] = 1'b0;
        @(negedge clk);
        check_output("t4_req_after_16th", 64'(bus.o_intr_req), 64'(INTR_BUILD));
        repeat (3) tick();
        @(negedge clk);
        check_output("t4_req_held", 64'(bus.o_intr_req), 64'(INTR_BUILD));
        tick();
        reg_read(ADDR_W'(32'h18), 32'd16);
`ifdef USER_STR_INTR_EN
        bus.i_pcie_str_ack[3] = 1'b1;
        repeat (16) tick();
        bus.i_pcie_str_ack[3] = 1'b0;
        bus.i_intr_ack = 1'b1;
        @(negedge clk);
        check_output("t4_req_at_ack", 64'(bus.o_intr_req), 64'h1);
        tick();
        bus.i_intr_ack = 1'b0;
        @(negedge clk);
        check_output("t4_req_dropped", 64'(bus.o_intr_req), 64'h0);
        tick();
        @(negedge clk);
        check_output("t4_req_reasserted", 64'(bus.o_intr_req), 64'h1);
        tick();
        bus.i_intr_ack = 1'b1;
        tick();
        bus.i_intr_ack = 1'b0;
        @(negedge clk);
        check_output("t4_req_dropped_again", 64'(bus.o_intr_req), 64'h0);
        repeat (2) tick();
        @(negedge clk);
        check_output("t4_no_spurious_req", 64'(bus.o_intr_req), 64'h0);
        tick();
        reg_read(ADDR_W'(32'h1C), 32'd16);
`endif
        drain(4'b1100);

        for (int n = 0; n < NUM_STR; n++) begin
            check_output($sformatf("end_ch%0d_outstanding", n), 64'(exp_q[n].size()), 64'h0);
        end
        check_output("end_rd_outstanding", 64'(rd_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
